// File: rtl/pll_mode_sequencer_if.sv
// Mode/lock/reset signals shared by the PAL/NTSC sequencer and its
// neighbours (config request side and clock block side).
interface pll_mode_sequencer_if;
  logic pal_req;
  logic pll_locked;
  logic pal_out;
  logic sys_reset_n;
  logic busy;
  logic timeout_err;

  modport slave (
    input  pal_req,
    input  pll_locked,
    output pal_out,
    output sys_reset_n,
    output busy,
    output timeout_err
  );

  modport master (
    output pal_req,
    output pll_locked,
    input  pal_out,
    input  sys_reset_n,
    input  busy,
    input  timeout_err
  );
endinterface

// File: rtl/pll_mode_sequencer.sv
// Sequences a PAL/NTSC change around PLL reconfiguration, holding the
// core in reset until lock has been stable after the new mode is applied.
module pll_mode_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE = 1024,
  parameter int PRE_HOLD    = 16,
  parameter int LOSS_WAIT   = 4096,
  parameter int TIMEOUT     = 65536
) (
  input  logic                 clk_i,
  input  logic                 reset_n,
  pll_mode_sequencer_if.slave  bus
);

  localparam int HMAX = (PRE_HOLD > LOSS_WAIT) ? PRE_HOLD : LOSS_WAIT;
  localparam int LW   = $clog2(LOCK_STABLE + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int HW   = $clog2(HMAX + 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_RUN,
    S_PRE_HOLD,
    S_APPLY,
    S_WAIT_LOSS
  } state_t;

  state_t                 state, state_n;
  logic [1:0]             pal_sync;
  logic [SYNC_STAGES-1:0] lk_sync;
  logic [LW-1:0]          lock_cnt, lock_cnt_n;
  logic [TW-1:0]          to_cnt, to_cnt_n;
  logic [HW-1:0]          hold_cnt, hold_cnt_n;
  logic                   pal_q, pal_n;
  logic                   srn_q, srn_n;
  logic                   terr_q, terr_n;
  logic                   pal_s, locked_s;

  assign pal_s    = pal_sync[1];
  assign locked_s = lk_sync[SYNC_STAGES-1];

  always_comb begin
    state_n    = state;
    lock_cnt_n = lock_cnt;
    to_cnt_n   = to_cnt;
    hold_cnt_n = hold_cnt;
    pal_n      = pal_q;
    srn_n      = srn_q;
    terr_n     = terr_q;
    unique case (state)
      S_WAIT_LOCK: begin
        if (!locked_s)
          lock_cnt_n = '0;
        else if (lock_cnt != LW'(LOCK_STABLE))
          lock_cnt_n = lock_cnt + LW'(1);
        if (to_cnt != TW'(TIMEOUT))
          to_cnt_n = to_cnt + TW'(1);
        if (to_cnt >= TW'(TIMEOUT - 1))
          terr_n = 1'b1;
        if (locked_s && lock_cnt >= LW'(LOCK_STABLE - 1)) begin
          state_n = S_RUN;
          srn_n   = 1'b1;
        end
      end
      S_RUN: begin
        // Lock loss wins over a pending mode request.
        if (!locked_s) begin
          state_n = S_WAIT_LOCK;
          srn_n   = 1'b0;
        end else if (pal_s != pal_q) begin
          state_n = S_PRE_HOLD;
          srn_n   = 1'b0;
        end
      end
      S_PRE_HOLD: begin
        if (hold_cnt >= HW'(PRE_HOLD - 1))
          state_n = (pal_s != pal_q) ? S_APPLY : S_WAIT_LOCK;
        else
          hold_cnt_n = hold_cnt + HW'(1);
      end
      S_APPLY: begin
        pal_n   = pal_s;
        state_n = S_WAIT_LOSS;
      end
      S_WAIT_LOSS: begin
        if (!locked_s || hold_cnt >= HW'(LOSS_WAIT - 1))
          state_n = S_WAIT_LOCK;
        else
          hold_cnt_n = hold_cnt + HW'(1);
      end
      default: begin
        state_n = S_WAIT_LOCK;
        srn_n   = 1'b0;
      end
    endcase
    if (state_n != state) begin
      lock_cnt_n = '0;
      to_cnt_n   = '0;
      hold_cnt_n = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_WAIT_LOCK;
      pal_sync <= '0;
      lk_sync  <= '0;
      lock_cnt <= '0;
      to_cnt   <= '0;
      hold_cnt <= '0;
      pal_q    <= 1'b0;
      srn_q    <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state    <= state_n;
      pal_sync <= {pal_sync[0], bus.pal_req};
      lk_sync  <= {lk_sync[SYNC_STAGES-2:0], bus.pll_locked};
      lock_cnt <= lock_cnt_n;
      to_cnt   <= to_cnt_n;
      hold_cnt <= hold_cnt_n;
      pal_q    <= pal_n;
      srn_q    <= srn_n;
      terr_q   <= terr_n;
    end
  end

  assign bus.pal_out     = pal_q;
  assign bus.sys_reset_n = srn_q;
  assign bus.timeout_err = terr_q;
  assign bus.busy        = (state != S_RUN);

endmodule
